// File: rtl/wam_pkg.sv
// Shared constants, FSM state type and LFSR/life helpers for the whack-a-mole hit block.
package wam_pkg;

   localparam logic [9:0] GAP_TICKS = 10'd200;
   localparam logic [9:0] LIFE_BASE = 10'd1000;
   localparam logic [9:0] LIFE_STEP = 10'd100;
   localparam logic [1:0] DB_TICKS  = 2'd3;
   localparam logic [7:0] LFSR_SEED = 8'hA5;

   typedef enum logic [1:0] {
      GAP  = 2'd0,
      SHOW = 2'd1,
      HIT  = 2'd2,
      MISS = 2'd3
   } wam_state_t;

   // Fibonacci LFSR with taps 8,6,5,4 (bits 7,5,4,3), shifting towards the MSB.
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic logic [9:0] life_of(input logic [2:0] lvl);
      return LIFE_BASE - (10'(lvl) * LIFE_STEP);
   endfunction

endpackage

// File: rtl/wam_dbn.sv
// One-bit tick-based debounce filter: the output follows the input only after
// the input has differed from it for DB_TICKS consecutive ticks.
module wam_dbn
   import wam_pkg::*;
(
   input  logic clk,
   input  logic clr,
   input  logic tick,
   input  logic in,
   output logic out
);

   logic [1:0] cnt_r;
   logic       out_r;

   // Stability counter; any clk where the input agrees with the output restarts it.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt_r <= 2'd0;
         out_r <= 1'b0;
      end else if (in == out_r) begin
         cnt_r <= 2'd0;
      end else if (tick) begin
         if (cnt_r == DB_TICKS - 2'd1) begin
            out_r <= in;
            cnt_r <= 2'd0;
         end else begin
            cnt_r <= cnt_r + 2'd1;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign out = out_r;

endmodule

// File: rtl/wam_hit.sv
// Whack-a-mole round controller: lights one mole at a time and reports hit/miss/wrong.
// Optional button debounce is enabled by defining WAM_HIT_DEBOUNCE_EN.
module wam_hit
   import wam_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       tick,
   input  logic [7:0] btn,
   input  logic       lvl_up,
   output logic [7:0] mole,
   output logic [7:0] hit,
   output logic       miss,
   output logic       wrong,
   output logic [2:0] level
);

   logic [7:0] btn_s1_r, btn_s2_r, btn_c_s, btn_d_r, press_s;
   logic       lvl_s1_r, lvl_s2_r, lvl_d_r;
   logic [7:0] lfsr_r;
   logic [2:0] level_r;

   wam_state_t state_r, state_s;
   logic [9:0] cnt_r, cnt_s;
   logic [9:0] life_r, life_s;
   logic [2:0] idx_r, idx_s, prev_r, prev_s, cand_s;
   logic [7:0] lit_s;
   logic [7:0] mole_r, mole_s, hit_r, hit_s;
   logic       miss_r, miss_s, wrong_r, wrong_s;

   // Two-flop synchronisers for the asynchronous inputs.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         btn_s1_r <= 8'd0;
         btn_s2_r <= 8'd0;
         lvl_s1_r <= 1'b0;
         lvl_s2_r <= 1'b0;
      end else begin
         btn_s1_r <= btn;
         btn_s2_r <= btn_s1_r;
         lvl_s1_r <= lvl_up;
         lvl_s2_r <= lvl_s1_r;
      end
   end

`ifdef WAM_HIT_DEBOUNCE_EN
   for (genvar i = 0; i < 8; i++) begin : g_dbn
      wam_dbn u_dbn (
         .clk  (clk),
         .clr  (clr),
         .tick (tick),
         .in   (btn_s2_r[i]),
         .out  (btn_c_s[i])
      );
   end
`else
   assign btn_c_s = btn_s2_r;
`endif

   assign press_s = btn_c_s & ~btn_d_r;

   // Edge-detect history, LFSR and saturating hardness level.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         btn_d_r <= 8'd0;
         lvl_d_r <= 1'b0;
         lfsr_r  <= LFSR_SEED;
         level_r <= 3'd0;
      end else begin
         btn_d_r <= btn_c_s;
         lvl_d_r <= lvl_s2_r;
         lfsr_r  <= lfsr_next(lfsr_r);
         if (lvl_s2_r && !lvl_d_r && (level_r != 3'd7)) begin
            level_r <= level_r + 3'd1;
         end else begin
            level_r <= level_r;
         end
      end
   end

   // Round FSM next-state and next-output logic.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      life_s  = life_r;
      idx_s   = idx_r;
      prev_s  = prev_r;
      lit_s   = 8'd1 << idx_r;
      cand_s  = (lfsr_r[2:0] == prev_r) ? (lfsr_r[2:0] + 3'd1) : lfsr_r[2:0];
      case (state_r)
         GAP: begin
            if (tick && (cnt_r == GAP_TICKS - 10'd1)) begin
               state_s = SHOW;
               cnt_s   = 10'd0;
               idx_s   = cand_s;
               prev_s  = cand_s;
               life_s  = life_of(level_r);
            end else if (tick) begin
               cnt_s = cnt_r + 10'd1;
            end else begin
               cnt_s = cnt_r;
            end
         end
         SHOW: begin
            // A lit press outranks expiry in the same clk.
            if (|(press_s & lit_s)) begin
               state_s = HIT;
               cnt_s   = 10'd0;
            end else if (tick && (cnt_r == life_r - 10'd1)) begin
               state_s = MISS;
               cnt_s   = 10'd0;
            end else if (tick) begin
               cnt_s = cnt_r + 10'd1;
            end else begin
               cnt_s = cnt_r;
            end
         end
         HIT: begin
            state_s = GAP;
            cnt_s   = 10'd0;
         end
         MISS: begin
            state_s = GAP;
            cnt_s   = 10'd0;
         end
         default: begin
            state_s = GAP;
            cnt_s   = 10'd0;
         end
      endcase
      wrong_s = (state_r == SHOW) && (|(press_s & ~lit_s)) && (state_s != MISS);
      mole_s  = (state_s == SHOW) ? (8'd1 << idx_s) : 8'd0;
      hit_s   = (state_s == HIT)  ? (8'd1 << idx_s) : 8'd0;
      miss_s  = (state_s == MISS);
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_r <= GAP;
         cnt_r   <= 10'd0;
         life_r  <= LIFE_BASE;
         idx_r   <= 3'd0;
         prev_r  <= 3'd0;
         mole_r  <= 8'd0;
         hit_r   <= 8'd0;
         miss_r  <= 1'b0;
         wrong_r <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         life_r  <= life_s;
         idx_r   <= idx_s;
         prev_r  <= prev_s;
         mole_r  <= mole_s;
         hit_r   <= hit_s;
         miss_r  <= miss_s;
         wrong_r <= wrong_s;
      end
   end

   assign mole  = mole_r;
   assign hit   = hit_r;
   assign miss  = miss_r;
   assign wrong = wrong_r;
   assign level = level_r;

endmodule
